frame_shift_out: RTL

//  Parallel-in, serial-out transmitter. Takes a WIDTH-bit light-pattern word held in a processor

---
 rtl/frame_shift_out_pkg.sv | 20 ++
 rtl/frame_shift_out_phase_timer.sv | 30 +++
 rtl/frame_shift_out.sv | 92 +++++++++
 3 files changed

// File: rtl/frame_shift_out_pkg.sv
// Shared definitions for the light-array serial transmitter: state encodings,
// default frame geometry and a counter-width helper.
package frame_shift_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH   = 64;
    localparam int DEFAULT_CLK_DIV = 4;

    // $clog2 with a floor of one bit, so a divide-by-one counter still has a register.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_shift_out_phase_timer.sv
// Phase divider: counts system clocks within one serial-clock phase and
// pulses phase_end on the last cycle of each phase.
module phase_timer
    import frame_shift_out_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic phase_end
);

    localparam int DIV_W = min1_clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;

    assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (clear || restart || phase_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/frame_shift_out.sv
// Parallel-in, serial-out light-pattern transmitter (MSB first, data/clock/latch).
// Define FRAME_SHIFT_PARITY_EN to append an even-parity bit after the data bits.
module frame_shift_out
    import frame_shift_out_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy,
    output logic             done
);

`ifdef FRAME_SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BIT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] frame_in;
    logic [BIT_W-1:0] bit_cnt;
    logic             phase_end;
    logic             accept;
    logic             last_bit;

`ifdef FRAME_SHIFT_PARITY_EN
    assign frame_in = {load_data, ^load_data};
`else
    assign frame_in = load_data;
`endif

    assign load_ready = (state == IDLE) && !clear;
    assign accept     = load_valid && load_ready;
    assign last_bit   = (bit_cnt == BIT_W'(NBITS - 1));

    // The divider is held at zero while idle so the first SETUP phase is full length.
    phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .clk       (clk),
        .clear     (clear),
        .restart   (state == IDLE),
        .phase_end (phase_end)
    );

    // NOTE: next-state is assigned a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)    state_nxt = SETUP;
            SETUP: if (phase_end) state_nxt = HOLD;
            HOLD:  if (phase_end) state_nxt = last_bit ? LATCH : SETUP;
            LATCH: if (phase_end) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == LATCH) && phase_end;
            if (accept) begin
                shreg   <= frame_in;
                bit_cnt <= '0;
            end else if ((state == HOLD) && phase_end && !last_bit) begin
                // Shifting on HOLD exit means ser_data only moves on SETUP entry.
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    assign ser_clk   = (state == HOLD);
    assign ser_latch = (state == LATCH);
    assign busy      = (state != IDLE);
    assign ser_data  = ((state == SETUP) || (state == HOLD)) && shreg[NBITS-1];

endmodule
